tc_round_robin_arbiter8: RTL and testbench



---
 rtl/tc_round_robin_arbiter8.sv | 158 +++++++++++++++
 tb/tb_tc_round_robin_arbiter8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_round_robin_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant and a one-cycle bubble per release.
// Optional hold-time limit enabled by defining TC_ARB_TIMEOUT_EN.
module tc_round_robin_arbiter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       dis,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       req4,
  input  logic       req5,
  input  logic       req6,
  input  logic       req7,
  input  logic       rel,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt4,
  output logic       gnt5,
  output logic       gnt6,
  output logic       gnt7,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  logic [7:0] req;
  logic       found;
  logic [2:0] win;
  logic [2:0] cand;
  logic       rel_cond;
  logic       force_rel;

  assign req = {req7, req6, req5, req4, req3, req2, req1, req0};

  // First asserted request scanning upward from ptr, wrapping modulo 8.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign rel_cond = rel | ~req[idx_q] | dis;

`ifdef TC_ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Counter at 15 means this edge would be the 16th of holding.
  assign force_rel = (cnt_q == 4'hF);
  assign timeout   = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef TC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (!dis && found) begin
          gnt_d   = 8'b1 << win;
          idx_d   = win;
          valid_d = 1'b1;
          state_d = StGrant;
`ifdef TC_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StGrant: begin
        if (rel_cond || force_rel) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
          state_d = StIdle;
`ifdef TC_ARB_TIMEOUT_EN
          timeout_d = ~rel_cond;
`endif
        end else begin
`ifdef TC_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef TC_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign gnt2      = gnt_q[2];
  assign gnt3      = gnt_q[3];
  assign gnt4      = gnt_q[4];
  assign gnt5      = gnt_q[5];
  assign gnt6      = gnt_q[6];
  assign gnt7      = gnt_q[7];
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_tc_round_robin_arbiter8.sv
// Scoreboarded bench for tc_round_robin_arbiter8: a behavioural model queues expected outputs
// per edge, plus directed constant checks for each scenario.
module tb_tc_round_robin_arbiter8;

`ifdef TC_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dis = 1'b0;
  logic       rel = 1'b0;
  logic [7:0] req = 8'h00;
  wire  [7:0] gnt;
  wire        gnt_valid;
  wire  [2:0] gnt_idx;
  wire        timeout;

  always #5 clk = ~clk;

  tc_round_robin_arbiter8 dut (
    .clk      (clk),
    .rst      (rst),
    .dis      (dis),
    .req0     (req[0]),
    .req1     (req[1]),
    .req2     (req[2]),
    .req3     (req[3]),
    .req4     (req[4]),
    .req5     (req[5]),
    .req6     (req[6]),
    .req7     (req[7]),
    .rel      (rel),
    .gnt0     (gnt[0]),
    .gnt1     (gnt[1]),
    .gnt2     (gnt[2]),
    .gnt3     (gnt[3]),
    .gnt4     (gnt[4]),
    .gnt5     (gnt[5]),
    .gnt6     (gnt[6]),
    .gnt7     (gnt[7]),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .timeout  (timeout)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit         m_busy = 1'b0;
  int         m_ptr  = 0;
  int         m_idx  = 0;
  int         m_cnt  = 0;
  logic [7:0] m_gnt  = 8'h00;
  logic       m_to   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    bit rl;
    bit forced;
    bit hit;
    int n;
    exp_t e;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_gnt = 8'h00; m_to = 1'b0;
    end else if (!m_busy) begin
      m_to  = 1'b0;
      m_gnt = 8'h00;
      m_idx = 0;
      if (!dis && req != 8'h00) begin
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
          n = (m_ptr + k) % 8;
          if (!hit && req[n]) begin
            hit = 1'b1;
            m_idx = n;
          end
        end
        m_gnt  = 8'h01 << m_idx;
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      rl     = rel || !req[m_idx] || dis;
      forced = ToEn && (m_cnt == 15);
      if (rl || forced) begin
        m_to   = forced && !rl;
        m_ptr  = (m_idx + 1) % 8;
        m_gnt  = 8'h00;
        m_idx  = 0;
        m_busy = 1'b0;
      end else begin
        m_to  = 1'b0;
        m_cnt = m_cnt + 1;
      end
    end
    e.gnt = m_gnt;
    e.v   = m_busy;
    e.idx = 3'(m_idx);
    e.to  = m_to;
    sb_q.push_back(e);
  endtask

  // One clock: queue the expectation for the current inputs, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    check_eq({tag, "_valid"}, 32'(gnt_valid), 32'(e.v));
    check_eq({tag, "_idx"}, 32'(gnt_idx), 32'(e.idx));
    check_eq({tag, "_timeout"}, 32'(timeout), 32'(e.to));
  endtask

  task automatic do_reset();
    rst = 1'b1; dis = 1'b0; rel = 1'b0; req = 8'h00;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("reset_gnt", 32'(gnt), 32'h0);
    check_eq("reset_valid", 32'(gnt_valid), 32'h0);
    step("idle");

    // Single request on 3
    req = 8'h08;
    step("req3");
    check_eq("req3_gnt", 32'(gnt), 32'h08);
    check_eq("req3_idx", 32'(gnt_idx), 32'd3);
    check_eq("req3_valid", 32'(gnt_valid), 32'd1);

    // All requesting, rel once per grant: 0..7 then 0, one bubble each
    do_reset();
    req = 8'hFF;
    step("rr_first");
    check_eq("rr_first_gnt", 32'(gnt), 32'h01);
    for (int g = 1; g <= 8; g++) begin
      rel = 1'b1;
      step("rr_rel");
      check_eq("rr_bubble", 32'(gnt), 32'h00);
      rel = 1'b0;
      step("rr_grant");
      check_eq("rr_gnt", 32'(gnt), 32'(8'h01 << (g % 8)));
    end

    // Holder 5, others raise, release -> 6 not 2
    do_reset();
    req = 8'h20;
    step("h5_grant");
    check_eq("h5_gnt", 32'(gnt), 32'h20);
    req = 8'h64;
    step("h5_hold");
    check_eq("h5_nopreempt", 32'(gnt), 32'h20);
    rel = 1'b1;
    step("h5_rel");
    check_eq("h5_bubble", 32'(gnt), 32'h00);
    rel = 1'b0;
    step("h5_next");
    check_eq("h5_next_gnt", 32'(gnt), 32'h40);

    // Disable during holder 7, then ptr wraps to 0
    do_reset();
    req = 8'h80;
    step("h7_grant");
    check_eq("h7_gnt", 32'(gnt), 32'h80);
    dis = 1'b1;
    step("h7_dis");
    check_eq("h7_dis_gnt", 32'(gnt), 32'h00);
    for (int i = 0; i < 4; i++) begin
      step("h7_dis_hold");
      check_eq("h7_dis_nogrant", 32'(gnt), 32'h00);
    end
    dis = 1'b0;
    req = 8'h81;
    step("h7_wrap");
    check_eq("h7_wrap_gnt", 32'(gnt), 32'h01);

    // Reset mid-grant on holder 4
    do_reset();
    req = 8'h10;
    step("h4_grant");
    check_eq("h4_gnt", 32'(gnt), 32'h10);
    rst = 1'b1;
    step("h4_rst");
    check_eq("h4_rst_gnt", 32'(gnt), 32'h00);
    check_eq("h4_rst_idx", 32'(gnt_idx), 32'h0);
    rst = 1'b0;
    req = 8'h11;
    step("h4_after");
    check_eq("h4_after_gnt", 32'(gnt), 32'h01);

    // Long hold on requester 1
    do_reset();
    req = 8'h02;
    step("to_grant");
    check_eq("to_gnt", 32'(gnt), 32'h02);
    if (ToEn) begin
      for (int i = 0; i < 15; i++) begin
        step("to_hold");
        check_eq("to_hold_gnt", 32'(gnt), 32'h02);
      end
      step("to_fire");
      check_eq("to_fire_gnt", 32'(gnt), 32'h00);
      check_eq("to_fire_pulse", 32'(timeout), 32'd1);
      step("to_regrant");
      check_eq("to_regrant_gnt", 32'(gnt), 32'h02);
      check_eq("to_regrant_pulse", 32'(timeout), 32'd0);
      // rel coinciding with the 16th edge suppresses the pulse
      for (int i = 0; i < 15; i++) step("to2_hold");
      rel = 1'b1;
      step("to2_rel");
      check_eq("to2_gnt", 32'(gnt), 32'h00);
      check_eq("to2_nopulse", 32'(timeout), 32'd0);
      rel = 1'b0;
      step("to2_regrant");
    end else begin
      for (int i = 0; i < 110; i++) begin
        step("hold");
        check_eq("hold_gnt", 32'(gnt), 32'h02);
        check_eq("hold_timeout", 32'(timeout), 32'd0);
      end
    end

    if (sb_q.size() != 0) begin
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
